maxpool_stream_unit: RTL and testbench

- Streaming max-pooling engine for the TNN feature path; successor to the two-input registered comparator.
- Reduces a window of consecutive input beats to one maximum per lane, across LANES independent lanes.
- Window length is selectable at runtime; input and output use valid/ready handshakes.
- Sits between the conv accumulator output and the feature write-back buffer.

---
 rtl/maxpool_stream_unit.sv | 139 +++++++++++++
 tb/tb_maxpool_stream_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream_unit.sv
// Streaming per-lane max-pooling engine with runtime window length and valid/ready on both sides.
// Define MAXPOOL_ARGMAX_EN to add out_index (per-lane beat position of the maximum, earliest wins on ties).
//
// state | meaning
// IDLE  | no partial window; next accepted beat opens one and samples cfg_pool_len
// ACCUM | window open; folding beats into the per-lane maxima
module maxpool_stream_unit #(
  parameter int FEATURE_WIDTH = 32,
  parameter int LANES         = 4,
  parameter int MAX_POOL      = 16,
  parameter int LEN_WIDTH     = 5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [LEN_WIDTH-1:0]             cfg_pool_len,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*FEATURE_WIDTH-1:0]   in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*FEATURE_WIDTH-1:0]   out_data,
  output logic [LEN_WIDTH-1:0]             out_count
`ifdef MAXPOOL_ARGMAX_EN
  ,
  output logic [LANES*LEN_WIDTH-1:0]       out_index
`endif
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_POOL);
  localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t state_q, state_d;

  logic [LEN_WIDTH-1:0]            len_q, len_eff, cnt_q, cnt_inc, beats_now;
  logic signed [FEATURE_WIDTH-1:0] acc_q    [LANES];
  logic signed [FEATURE_WIDTH-1:0] lane_in  [LANES];
  logic signed [FEATURE_WIDTH-1:0] lane_max [LANES];
  logic                            beat, close_win, emit;

  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    if (cfg_pool_len == '0)
      len_eff = ONE;
    else if (cfg_pool_len > MAX_LEN)
      len_eff = MAX_LEN;
    else
      len_eff = cfg_pool_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat && !close_win) state_d = ACCUM;
      ACCUM:   if (emit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !out_valid || out_ready;
    beat      = in_valid && in_ready;
    beats_now = (state_q == IDLE) ? ONE : cnt_inc;
    close_win = (state_q == IDLE) ? ((len_eff == ONE) || in_last)
                                  : ((cnt_inc == len_q) || in_last);
    emit      = beat && close_win;
  end

  // The first beat of a window loads directly; later beats keep the larger (ties take the new beat).
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l]  = in_data[l*FEATURE_WIDTH +: FEATURE_WIDTH];
      lane_max[l] = lane_in[l];
      if (state_q == ACCUM && lane_in[l] < acc_q[l])
        lane_max[l] = acc_q[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
      cnt_q     <= '0;
      len_q     <= ONE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      out_valid <= emit || (out_valid && !out_ready);
      if (beat) begin
        for (int l = 0; l < LANES; l++) acc_q[l] <= lane_max[l];
        cnt_q <= emit ? '0 : beats_now;
        if (state_q == IDLE) len_q <= len_eff;
      end
      if (emit) begin
        for (int l = 0; l < LANES; l++)
          out_data[l*FEATURE_WIDTH +: FEATURE_WIDTH] <= lane_max[l];
        out_count <= beats_now;
      end
    end
  end

`ifdef MAXPOOL_ARGMAX_EN
  logic [LEN_WIDTH-1:0] idx_q   [LANES];
  logic [LEN_WIDTH-1:0] idx_new [LANES];

  // Index moves only on a strictly greater value so the earliest tied beat is reported.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      idx_new[l] = '0;
      if (state_q == ACCUM)
        idx_new[l] = (lane_in[l] > acc_q[l]) ? cnt_q : idx_q[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < LANES; l++) idx_q[l] <= '0;
      out_index <= '0;
    end else begin
      if (beat)
        for (int l = 0; l < LANES; l++) idx_q[l] <= idx_new[l];
      if (emit)
        for (int l = 0; l < LANES; l++)
          out_index[l*LEN_WIDTH +: LEN_WIDTH] <= idx_new[l];
    end
  end
`endif

endmodule

// File: tb/tb_maxpool_stream_unit.sv
// Bench for maxpool_stream_unit: window-level reference model plus directed literal cases and random traffic.
module tb_maxpool_stream_unit;

  localparam int FW = 32;
  localparam int NL = 4;
  localparam int MP = 16;
  localparam int LW = 5;
  localparam int DW = NL*FW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW-1:0] cfg_pool_len;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [LW-1:0] out_count;
`ifdef MAXPOOL_ARGMAX_EN
  logic [NL*LW-1:0] out_index;
`endif

  maxpool_stream_unit #(.FEATURE_WIDTH(FW), .LANES(NL), .MAX_POOL(MP), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_pool_len (cfg_pool_len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_count    (out_count)
`ifdef MAXPOOL_ARGMAX_EN
    ,
    .out_index    (out_index)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    d;
    logic [LW-1:0]    c;
    logic [NL*LW-1:0] ix;
  } res_t;

  res_t          exp_q[$];
  logic [DW-1:0] win_q[$];
  int            win_len;
  int            checks = 0;
  int            failures = 0;
  bit            hold = 0;
  logic [DW-1:0] held_d;
  logic [LW-1:0] held_c;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int clamp_len(input logic [LW-1:0] c);
    if (c == 0) return 1;
    if (int'(c) > MP) return MP;
    return int'(c);
  endfunction

  function automatic logic [DW-1:0] mk0(input logic [FW-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    r[FW-1:0] = v;
    return r;
  endfunction

  // Whole-window reference: collect beats, then take per-lane max and earliest position of it.
  task automatic model_accept();
    res_t r;
    if (win_q.size() == 0) win_len = clamp_len(cfg_pool_len);
    win_q.push_back(in_data);
    if (in_last || win_q.size() == win_len) begin
      r.d  = '0;
      r.ix = '0;
      for (int l = 0; l < NL; l++) begin
        logic [DW-1:0] w;
        logic signed [FW-1:0] best, v;
        int bi;
        w = win_q[0];
        best = w[l*FW +: FW];
        bi = 0;
        for (int b = 1; b < win_q.size(); b++) begin
          w = win_q[b];
          v = w[l*FW +: FW];
          if (v > best) begin
            best = v;
            bi = b;
          end
        end
        r.d[l*FW +: FW]  = best;
        r.ix[l*LW +: LW] = LW'(bi);
      end
      r.c = LW'(win_q.size());
      exp_q.push_back(r);
      win_q.delete();
    end
  endtask

  task automatic monitor();
    res_t r;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        win_q.delete();
        exp_q.delete();
        hold = 0;
      end else begin
        chk("in_ready_rule", in_ready, !out_valid || out_ready);
        chk("out_valid_timing", out_valid, exp_q.size() != 0);
        if (hold) begin
          chk("stall_data", out_data, held_d);
          chk("stall_count", out_count, held_c);
        end
        hold   = out_valid && !out_ready;
        held_d = out_data;
        held_c = out_count;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got data %0h expected no result", out_data);
          end else begin
            r = exp_q.pop_front();
            chk("model_data", out_data, r.d);
            chk("model_count", out_count, r.c);
`ifdef MAXPOOL_ARGMAX_EN
            chk("model_index", out_index, r.ix);
`endif
          end
        end
        if (in_valid && in_ready) model_accept();
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the beat was taken.
  task automatic send(input logic [DW-1:0] d, input logic last, input logic [LW-1:0] cfg, input bit rnd);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    cfg_pool_len = cfg;
    for (int n = 0; n < 1000; n++) begin
      #1;
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    if (ok) begin
      @(negedge clk);
    end else begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 1000 cycles");
      in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [FW-1:0] rand_lane();
    case ($urandom_range(0, 3))
      0:       return FW'($urandom);
      1:       return FW'($signed($urandom_range(0, 6)) - 3);
      2:       return 32'h8000_0000;
      default: return 32'h7FFF_FFFF;
    endcase
  endfunction

  initial begin
    logic [DW-1:0] d;
    rst_n = 1'b0;
    cfg_pool_len = '0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, '0);
    chk("reset_out_count", out_count, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);

    // len 4, lane0 3,-7,12,5
    send(mk0(32'd3), 0, 5'd4, 0);
    send(mk0(-32'sd7), 0, 5'd4, 0);
    send(mk0(32'd12), 0, 5'd4, 0);
    chk("len4_no_early_emit", out_valid, 1'b0);
    send(mk0(32'd5), 0, 5'd4, 0);
    chk("len4_valid", out_valid, 1'b1);
    chk("len4_data", out_data, mk0(32'd12));
    chk("len4_count", out_count, 5'd4);
`ifdef MAXPOOL_ARGMAX_EN
    chk("len4_index", out_index[LW-1:0], 5'd2);
`endif
    idle(1);

    // most-negative ties then -1
    send({NL{32'h8000_0000}}, 0, 5'd3, 0);
    send({NL{32'h8000_0000}}, 0, 5'd3, 0);
    send({NL{32'hFFFF_FFFF}}, 0, 5'd3, 0);
    chk("neg_data", out_data, {NL{32'hFFFF_FFFF}});
    chk("neg_count", out_count, 5'd3);
`ifdef MAXPOOL_ARGMAX_EN
    chk("neg_index", out_index, {NL{5'd2}});
`endif
    idle(1);

    // len 8 closed early by in_last; cfg change mid-window ignored
    send(mk0(32'd1), 0, 5'd8, 0);
    send(mk0(32'd9), 0, 5'd2, 0);
    chk("mid_cfg_ignored", out_valid, 1'b0);
    send(mk0(32'd2), 1, 5'd2, 0);
    chk("last_data", out_data, mk0(32'd9));
    chk("last_count", out_count, 5'd3);
    idle(1);
    send(mk0(32'd4), 0, 5'd2, 0);
    send(mk0(32'd5), 0, 5'd2, 0);
    chk("restart_data", out_data, mk0(32'd5));
    chk("restart_count", out_count, 5'd2);
    idle(1);

    // backpressure stall
    out_ready = 1'b0;
    send(mk0(32'd77), 0, 5'd1, 0);
    in_data = mk0(32'd88);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_hold", out_data, mk0(32'd77));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("release_valid", out_valid, 1'b1);
    chk("release_data", out_data, mk0(32'd88));
    idle(1);

    // len 1 and len 0 stream one result per beat
    for (int k = 0; k < 6; k++) begin
      d = mk0(32'(10 * (k % 3 + 1) + k / 3));
      send(d, 0, (k < 3) ? 5'd1 : 5'd0, 0);
      chk("len1_valid", out_valid, 1'b1);
      chk("len1_data", out_data, d);
      chk("len1_count", out_count, 5'd1);
    end
    idle(1);

    // reset mid-window discards partial data
    send(mk0(32'd50), 0, 5'd4, 0);
    send(mk0(32'd60), 0, 5'd4, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) send(mk0(32'(k)), 0, 5'd4, 0);
    chk("post_rst_data", out_data, mk0(32'd4));
    chk("post_rst_count", out_count, 5'd4);
    idle(1);

    // random traffic
    for (int b = 0; b < 400; b++) begin
      int gap;
      gap = $urandom_range(0, 2);
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      for (int l = 0; l < NL; l++) d[l*FW +: FW] = rand_lane();
      send(d, ($urandom_range(0, 7) == 0), LW'($urandom_range(0, 31)), 1);
    end
    out_ready = 1'b1;
    idle(4);
    chk("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
